// File: rtl/instr_register_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_register_pkg
// Description : Shared types for the instruction register and its reader.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_register_pkg;

   localparam int DEPTH = 32;
   localparam int RES_W = 64;

   typedef enum logic [3:0] {
      ZERO  = 4'd0,
      PASSA = 4'd1,
      PASSB = 4'd2,
      ADD   = 4'd3,
      SUB   = 4'd4,
      MULT  = 4'd5,
      DIV   = 4'd6,
      MOD   = 4'd7
   } opcode_t;

   typedef logic signed [31:0]              operand_t;
   typedef logic        [$clog2(DEPTH)-1:0] address_t;

   typedef struct packed {
      opcode_t  opc;
      operand_t op_a;
      operand_t op_b;
   } instruction_t;

   typedef logic signed [RES_W-1:0] result_t;

   typedef enum logic [2:0] {
      RD_IDLE  = 3'd0,
      RD_FETCH = 3'd1,
      RD_EXEC  = 3'd2,
      RD_OUT   = 3'd3,
      RD_FIN   = 3'd4
   } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_alu.sv
`default_nettype none
// ============================================================================
// Module      : instr_alu
// Description : Combinational executor for one instruction word.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_alu
   import instr_register_pkg::*;
(
   input  instruction_t instr,
   output result_t      result,
   output logic         div0
);

   result_t w_a;
   result_t w_b;
   logic    w_b_zero;

   always_comb begin
      w_a      = result_t'(instr.op_a);
      w_b      = result_t'(instr.op_b);
      w_b_zero = (instr.op_b == '0);
      result   = '0;
      div0     = 1'b0;
      case (instr.opc)
         ZERO:  result = '0;
         PASSA: result = w_a;
         PASSB: result = w_b;
         ADD:   result = w_a + w_b;
         SUB:   result = w_a - w_b;
         MULT:  result = w_a * w_b;
         DIV: begin
            if (w_b_zero) div0   = 1'b1;
            else          result = w_a / w_b;
         end
         MOD: begin
            if (w_b_zero) div0   = 1'b1;
            else          result = w_a % w_b;
         end
         default: result = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/instr_reg_reader.sv
`default_nettype none
// ============================================================================
// Module      : instr_reg_reader
// Description : Walks a run of instruction slots, executes each, streams results.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_reg_reader
   import instr_register_pkg::instruction_t, instr_register_pkg::opcode_t,
          instr_register_pkg::result_t, instr_register_pkg::rd_state_t,
          instr_register_pkg::RD_IDLE, instr_register_pkg::RD_FETCH,
          instr_register_pkg::RD_EXEC, instr_register_pkg::RD_OUT,
          instr_register_pkg::RD_FIN;
#(
   parameter int DEPTH = 32,
   parameter int RES_W = 64
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [$clog2(DEPTH)-1:0] start_addr,
   input  logic [$clog2(DEPTH):0]   count,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(DEPTH)-1:0] read_pointer,
   input  instruction_t             instruction_word,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic signed [RES_W-1:0]  res_data,
   output opcode_t                  res_opcode,
   output logic [$clog2(DEPTH)-1:0] res_addr,
   output logic                     res_div0
);

   localparam int AW = $clog2(DEPTH);

   rd_state_t               r_state;
   logic                    r_busy;
   logic                    r_done;
   logic [AW-1:0]           r_read_pointer;
   logic [AW:0]             r_remaining;
   instruction_t            r_word;
   logic [AW-1:0]           r_addr;
   logic                    r_res_valid;
   logic signed [RES_W-1:0] r_res_data;
   opcode_t                 r_res_opcode;
   logic [AW-1:0]           r_res_addr;
   logic                    r_res_div0;

   result_t w_alu_result;
   logic    w_alu_div0;

   instr_alu u_alu (
      .instr  (r_word),
      .result (w_alu_result),
      .div0   (w_alu_div0)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= RD_IDLE;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_read_pointer <= '0;
         r_remaining    <= '0;
         r_word         <= '0;
         r_addr         <= '0;
         r_res_valid    <= 1'b0;
         r_res_data     <= '0;
         r_res_opcode   <= opcode_t'('0);
         r_res_addr     <= '0;
         r_res_div0     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            RD_IDLE: begin
               if (start) begin
                  r_busy <= 1'b1;
                  if (count != '0) begin
                     r_remaining    <= count;
                     r_read_pointer <= start_addr;
                     r_state        <= RD_FETCH;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= RD_FIN;
                  end
               end
            end
            RD_FETCH: begin
               r_word  <= instruction_word;
               r_addr  <= r_read_pointer;
               r_state <= RD_EXEC;
            end
            RD_EXEC: begin
               r_res_data   <= RES_W'(w_alu_result);
               r_res_opcode <= r_word.opc;
               r_res_addr   <= r_addr;
               r_res_div0   <= w_alu_div0;
               r_res_valid  <= 1'b1;
               r_state      <= RD_OUT;
            end
            RD_OUT: begin
               if (r_res_valid && res_ready) begin
                  r_res_valid <= 1'b0;
                  r_remaining <= r_remaining - 1'b1;
                  if (r_remaining == (AW+1)'(1)) begin
                     r_done  <= 1'b1;
                     r_state <= RD_FIN;
                  end else begin
                     // Explicit wrap keeps non-power-of-two depths correct
                     r_read_pointer <= (r_read_pointer == AW'(DEPTH-1)) ?
                                       '0 : r_read_pointer + 1'b1;
                     r_state        <= RD_FETCH;
                  end
               end
            end
            RD_FIN: begin
               r_busy  <= 1'b0;
               r_state <= RD_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= RD_IDLE;
            end
         endcase
      end
   end

   assign busy         = r_busy;
   assign done         = r_done;
   assign read_pointer = r_read_pointer;
   assign res_valid    = r_res_valid;
   assign res_data     = r_res_data;
   assign res_opcode   = r_res_opcode;
   assign res_addr     = r_res_addr;
   assign res_div0     = r_res_div0;

endmodule
`default_nettype wire
